// File: rtl/phase_accum_q22_pkg.sv
// phase_accum_q22_pkg: Q2.22 angle constants, reduced-angle type and angle helpers.
//   PI_Q22 / TWO_PI_Q22  : pi and 2*pi in unsigned Q2.22
//   angle_half_t         : {half, theta} result of folding an angle into [0, pi)
//   reduce_half_q22(p)   : fold p in [0, 2*pi) into [0, pi) plus half-cycle flag
//   mod_two_pi_q22(s)    : single-subtract reduction of s in [0, 4*pi) into [0, 2*pi)
package phase_accum_q22_pkg;
  localparam logic [23:0] PI_Q22 = 24'd13176795;
  localparam logic [24:0] TWO_PI_Q22 = 25'd26353590;
  typedef struct packed {
    logic        half;
    logic [23:0] theta;
  } angle_half_t;
  function automatic angle_half_t reduce_half_q22(input logic [24:0] p);
    logic ge;
    ge = p >= {1'b0, PI_Q22};
    return '{half: ge, theta: ge ? 24'(p - {1'b0, PI_Q22}) : p[23:0]};
  endfunction
  function automatic logic [24:0] mod_two_pi_q22(input logic [25:0] s);
    return s >= {1'b0, TWO_PI_Q22} ? 25'(s - {1'b0, TWO_PI_Q22}) : s[24:0];
  endfunction
endpackage

// File: rtl/phase_accum_q22_if.sv
// phase_accum_q22_if: control inputs and output sample stream of the phase accumulator.
//   en, freq_word, freq_load, phase_sync, phase_off, out_ready : driven by master
//   out_valid, theta_out, theta_half, wrap_out                  : driven by slave (accumulator)
interface phase_accum_q22_if;
  logic        en;
  logic [23:0] freq_word;
  logic        freq_load;
  logic        phase_sync;
  logic [23:0] phase_off;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] theta_out;
  logic        theta_half;
  logic        wrap_out;
  modport master (
    output en, freq_word, freq_load, phase_sync, phase_off, out_ready,
    input  out_valid, theta_out, theta_half, wrap_out
  );
  modport slave (
    input  en, freq_word, freq_load, phase_sync, phase_off, out_ready,
    output out_valid, theta_out, theta_half, wrap_out
  );
endinterface

// File: rtl/phase_accum_q22_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) used as phase dither.
//   clk, rst  : clock, synchronous active-high reset (reloads seed)
//   step_i    : advance one state
//   lfsr_o    : low OUT_BITS bits of the register
// Only built when PHASE_DITHER_EN is defined.
`ifdef PHASE_DITHER_EN
module lfsr16 #(
  parameter int OUT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_i,
  output logic [OUT_BITS-1:0] lfsr_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk)
    if (rst) lfsr_q <= 16'hACE1;
    else if (step_i) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign lfsr_o = lfsr_q[OUT_BITS-1:0];
endmodule
`endif

// File: rtl/phase_accum_q22.sv
// phase_accum_q22: NCO phase accumulator modulo 2*pi, emitting angles folded into [0, pi).
//   clk, rst : clock, synchronous active-high reset
//   acc_io   : phase_accum_q22_if.slave (en, freq_word/freq_load, phase_sync/phase_off,
//              valid/ready output stream theta_out, theta_half, wrap_out)
// Optional: define PHASE_DITHER_EN to add LFSR dither to theta_out LSBs (saturated below pi).
module phase_accum_q22
  import phase_accum_q22_pkg::*;
#(
  parameter int DITHER_BITS = 4
) (
  input logic              clk,
  input logic              rst,
  phase_accum_q22_if.slave acc_io
);
  if (DITHER_BITS < 1 || DITHER_BITS > 16) begin : g_bad_dither
    $error("DITHER_BITS must be in 1..16");
  end
  logic [24:0] phase_q, phase_d;
  logic [23:0] inc_q, theta_q, theta_d;
  logic        wrap_q, wrap_d, valid_q, half_q, wrap_out_q, adv;
  logic [25:0] sum;
  angle_half_t red;
  assign adv = acc_io.en && (!valid_q || acc_io.out_ready);
  assign red = reduce_half_q22(phase_q);
  assign sum = {1'b0, phase_q} + {2'b0, inc_q};
  always_comb begin
    phase_d = acc_io.phase_sync ? mod_two_pi_q22({2'b0, acc_io.phase_off}) :
              adv ? mod_two_pi_q22(sum) : phase_q;
    wrap_d  = acc_io.phase_sync ? 1'b0 : adv ? sum >= {1'b0, TWO_PI_Q22} : wrap_q;
  end
`ifdef PHASE_DITHER_EN
  logic [DITHER_BITS-1:0] dither;
  logic [24:0]            dith_sum;
  lfsr16 #(.OUT_BITS(DITHER_BITS)) u_lfsr (.clk(clk), .rst(rst), .step_i(adv), .lfsr_o(dither));
  assign dith_sum = {1'b0, red.theta} + 25'(dither);
  assign theta_d  = dith_sum >= {1'b0, PI_Q22} ? PI_Q22 - 24'd1 : dith_sum[23:0];
`else
  assign theta_d = red.theta;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      phase_q    <= '0;
      inc_q      <= '0;
      wrap_q     <= 1'b0;
      valid_q    <= 1'b0;
      theta_q    <= '0;
      half_q     <= 1'b0;
      wrap_out_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      if (acc_io.freq_load) inc_q <= acc_io.freq_word;
      if (adv) begin
        valid_q    <= 1'b1;
        theta_q    <= theta_d;
        half_q     <= red.half;
        wrap_out_q <= wrap_q;
      end else if (acc_io.out_ready) valid_q <= 1'b0;
    end
  assign acc_io.out_valid  = valid_q;
  assign acc_io.theta_out  = theta_q;
  assign acc_io.theta_half = half_q;
  assign acc_io.wrap_out   = wrap_out_q;
endmodule

// File: tb/tb_phase_accum_q22.sv
// tb_phase_accum_q22: table-driven, directed and randomized checks of phase_accum_q22.
module tb_phase_accum_q22;
  localparam longint PI = 13176795;
  localparam longint TWO_PI = 26353590;
  localparam longint F = 4194304;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  phase_accum_q22_if acc ();
  phase_accum_q22 dut (.clk(clk), .rst(rst), .acc_io(acc));
  int checks = 0;
  int errors = 0;
  longint m_phase, m_inc, m_theta;
  bit m_wrap, m_valid, m_half, m_wo;
  typedef struct {
    longint freq;
    longint theta;
    bit     half;
    bit     wrap;
  } vec_t;
  vec_t tbl[9];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic chk_theta(input string name, input logic [63:0] act, input longint ideal);
`ifdef PHASE_DITHER_EN
    checks++;
    if ($isunknown(act) || act < ideal || act >= ideal + 16 || act >= PI) begin
      errors++;
      $display("FAIL %s actual=%0d required=[%0d,%0d) below %0d", name, act, ideal, ideal + 16, PI);
    end
`else
    check(name, act, ideal);
`endif
  endtask
  task automatic step();
    bit adv;
    longint s;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_inc = 0; m_wrap = 0; m_valid = 0; m_theta = 0; m_half = 0; m_wo = 0;
    end else begin
      adv = acc.en && (!m_valid || acc.out_ready);
      s = m_phase + m_inc;
      if (adv) begin
        m_theta = m_phase % PI;
        m_half  = m_phase >= PI;
        m_wo    = m_wrap;
        m_valid = 1;
      end else if (m_valid && acc.out_ready) m_valid = 0;
      if (acc.phase_sync) begin
        m_phase = longint'(acc.phase_off) % TWO_PI;
        m_wrap  = 0;
      end else if (adv) begin
        m_wrap  = s >= TWO_PI;
        m_phase = s % TWO_PI;
      end
      if (acc.freq_load) m_inc = longint'(acc.freq_word);
    end
    #1;
    check("model_valid", acc.out_valid, m_valid);
    if (m_valid) begin
      chk_theta("model_theta", acc.theta_out, m_theta);
      check("model_half", acc.theta_half, m_half);
      check("model_wrap", acc.wrap_out, m_wo);
    end
  endtask
  task automatic restart(input longint f);
    rst = 1; acc.en = 0; acc.freq_load = 0; acc.phase_sync = 0; acc.out_ready = 1;
    step();
    check("rst_valid", acc.out_valid, 0);
    check("rst_theta", acc.theta_out, 0);
    check("rst_half", acc.theta_half, 0);
    check("rst_wrap", acc.wrap_out, 0);
    rst = 0; acc.freq_word = 24'(f); acc.freq_load = 1;
    step();
    acc.freq_load = 0; acc.en = 1;
  endtask
  initial begin
    longint prev;
    acc.en = 0; acc.freq_word = 0; acc.freq_load = 0; acc.phase_sync = 0;
    acc.phase_off = 0; acc.out_ready = 0;
    tbl[0] = '{F, 0, 0, 0};
    tbl[1] = '{F, 4194304, 0, 0};
    tbl[2] = '{F, 8388608, 0, 0};
    tbl[3] = '{F, 12582912, 0, 0};
    tbl[4] = '{F, 3600421, 1, 0};
    tbl[5] = '{PI, 0, 0, 0};
    tbl[6] = '{PI, 0, 1, 0};
    tbl[7] = '{PI, 0, 0, 1};
    tbl[8] = '{PI, 0, 1, 0};
    prev = -1;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].freq != prev) restart(tbl[i].freq);
      prev = tbl[i].freq;
      step();
      check("tbl_valid", acc.out_valid, 1);
      chk_theta("tbl_theta", acc.theta_out, tbl[i].theta);
      check("tbl_half", acc.theta_half, tbl[i].half);
      check("tbl_wrap", acc.wrap_out, tbl[i].wrap);
    end
    step();
    check("wrap_pulse_again", acc.wrap_out, 1);
    step();
    check("wrap_pulse_clear", acc.wrap_out, 0);
    restart(F);
    step();
    step();
    acc.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", acc.out_valid, 1);
      chk_theta("bp_hold", acc.theta_out, F);
    end
    acc.out_ready = 1;
    step();
    chk_theta("bp_release", acc.theta_out, 2 * F);
    step();
    chk_theta("bp_next", acc.theta_out, 3 * F);
    acc.phase_sync = 1; acc.phase_off = 24'd13176805;
    step();
    chk_theta("sync_cur", acc.theta_out, 4 * F - PI);
    acc.phase_sync = 0;
    step();
    chk_theta("sync_theta", acc.theta_out, 10);
    check("sync_half", acc.theta_half, 1);
    check("sync_wrap", acc.wrap_out, 0);
    acc.out_ready = 0;
    step();
    check("stall_valid", acc.out_valid, 1);
    rst = 1;
    step();
    check("rststall_valid", acc.out_valid, 0);
    rst = 0; acc.out_ready = 1;
    step();
    check("rststall_new_valid", acc.out_valid, 1);
    chk_theta("rststall_theta", acc.theta_out, 0);
    restart(F);
    step();
    acc.freq_word = 24'd1000; acc.freq_load = 1;
    step();
    chk_theta("fl_old", acc.theta_out, F);
    acc.freq_load = 0;
    step();
    chk_theta("fl_last_big", acc.theta_out, 2 * F);
    step();
    chk_theta("fl_small1", acc.theta_out, 2 * F + 1000);
    step();
    chk_theta("fl_small2", acc.theta_out, 2 * F + 2000);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      acc.en = $urandom_range(0, 9) < 8;
      acc.out_ready = $urandom_range(0, 9) < 7;
      acc.freq_load = $urandom_range(0, 19) == 0;
      acc.freq_word = 24'($urandom);
      acc.phase_sync = $urandom_range(0, 39) == 0;
      acc.phase_off = 24'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
